// File: rtl/dht_frame_check.sv
// Captures raw 40-bit DHT frames, validates checksum/stuck-line, commits good readings and tracks faults/age.
// Optional range check on committed values is built when DHT_PLAUSIBILITY_EN is defined.
module dht_frame_check #(
  parameter int TIMEOUT_CYC = 12_000_000,
  parameter int MAX_FAIL    = 3
) (
  input  logic        clk1M,
  input  logic        rst_n,
  input  logic [39:0] frame_in,
  input  logic        frame_stb,
  output logic [7:0]  hum_int,
  output logic [7:0]  hum_dec,
  output logic [7:0]  temp_int,
  output logic [7:0]  temp_dec,
  output logic        data_valid,
  output logic        upd_pulse,
  output logic        stale,
  output logic        sensor_fault,
  output logic [7:0]  crc_err_cnt
);

  localparam logic [23:0] TIMEOUT_V  = 24'(TIMEOUT_CYC);
  localparam logic [3:0]  MAX_FAIL_V = 4'(MAX_FAIL);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, REJECT} state_t;

  state_t      state_q, state_d;
  logic [39:0] frame_q, frame_d;
  logic [7:0]  hum_int_q, hum_int_d, hum_dec_q, hum_dec_d;
  logic [7:0]  temp_int_q, temp_int_d, temp_dec_q, temp_dec_d;
  logic        data_valid_q, data_valid_d;
  logic        upd_pulse_q, upd_pulse_d;
  logic        stale_q, stale_d;
  logic        sensor_fault_q, sensor_fault_d;
  logic [7:0]  crc_err_cnt_q, crc_err_cnt_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [23:0] age_q, age_d;

  logic [7:0]  sum8;
  logic        range_ok;
  logic        frame_good;

  assign sum8 = frame_q[39:32] + frame_q[31:24] + frame_q[23:16] + frame_q[15:8];

`ifdef DHT_PLAUSIBILITY_EN
  assign range_ok = (frame_q[39:32] <= 8'd100) && (frame_q[31:24] <= 8'd9) &&
                    (frame_q[23:16] <= 8'd60)  && (frame_q[15:8]  <= 8'd9);
`else
  assign range_ok = 1'b1;
`endif

  // An all-zero frame sums correctly but means the data line is stuck low.
  assign frame_good = (sum8 == frame_q[7:0]) && (frame_q != 40'd0) && range_ok;

  always_comb begin
    state_d        = state_q;
    frame_d        = frame_q;
    hum_int_d      = hum_int_q;
    hum_dec_d      = hum_dec_q;
    temp_int_d     = temp_int_q;
    temp_dec_d     = temp_dec_q;
    upd_pulse_d    = 1'b0;
    sensor_fault_d = sensor_fault_q;
    crc_err_cnt_d  = crc_err_cnt_q;
    fail_cnt_d     = fail_cnt_q;
    age_d          = (age_q == TIMEOUT_V) ? age_q : age_q + 24'd1;
    stale_d        = (age_d == TIMEOUT_V);
    data_valid_d   = data_valid_q & ~stale_d;

    case (state_q)
      IDLE: begin
        if (frame_stb) begin
          frame_d = frame_in;
          state_d = CHECK;
        end
      end
      CHECK: state_d = frame_good ? COMMIT : REJECT;
      COMMIT: begin
        hum_int_d      = frame_q[39:32];
        hum_dec_d      = frame_q[31:24];
        temp_int_d     = frame_q[23:16];
        temp_dec_d     = frame_q[15:8];
        upd_pulse_d    = 1'b1;
        // Commit overrides a timeout landing in the same cycle.
        age_d          = 24'd0;
        stale_d        = 1'b0;
        data_valid_d   = 1'b1;
        fail_cnt_d     = 4'd0;
        sensor_fault_d = 1'b0;
        state_d        = IDLE;
      end
      REJECT: begin
        if (crc_err_cnt_q != 8'hFF) crc_err_cnt_d = crc_err_cnt_q + 8'd1;
        if (fail_cnt_q < MAX_FAIL_V) fail_cnt_d = fail_cnt_q + 4'd1;
        sensor_fault_d = (fail_cnt_d >= MAX_FAIL_V);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk1M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      frame_q        <= '0;
      hum_int_q      <= '0;
      hum_dec_q      <= '0;
      temp_int_q     <= '0;
      temp_dec_q     <= '0;
      data_valid_q   <= 1'b0;
      upd_pulse_q    <= 1'b0;
      stale_q        <= 1'b0;
      sensor_fault_q <= 1'b0;
      crc_err_cnt_q  <= '0;
      fail_cnt_q     <= '0;
      age_q          <= '0;
    end else begin
      state_q        <= state_d;
      frame_q        <= frame_d;
      hum_int_q      <= hum_int_d;
      hum_dec_q      <= hum_dec_d;
      temp_int_q     <= temp_int_d;
      temp_dec_q     <= temp_dec_d;
      data_valid_q   <= data_valid_d;
      upd_pulse_q    <= upd_pulse_d;
      stale_q        <= stale_d;
      sensor_fault_q <= sensor_fault_d;
      crc_err_cnt_q  <= crc_err_cnt_d;
      fail_cnt_q     <= fail_cnt_d;
      age_q          <= age_d;
    end
  end

  assign hum_int      = hum_int_q;
  assign hum_dec      = hum_dec_q;
  assign temp_int     = temp_int_q;
  assign temp_dec     = temp_dec_q;
  assign data_valid   = data_valid_q;
  assign upd_pulse    = upd_pulse_q;
  assign stale        = stale_q;
  assign sensor_fault = sensor_fault_q;
  assign crc_err_cnt  = crc_err_cnt_q;

endmodule

// File: tb/tb_dht_frame_check.sv
// Directed bench for dht_frame_check with a short timeout; expectations are hand-computed.
module tb_dht_frame_check;

  logic        clk1M = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] frame_in = '0;
  logic        frame_stb = 1'b0;
  logic [7:0]  hum_int, hum_dec, temp_int, temp_dec, crc_err_cnt;
  logic        data_valid, upd_pulse, stale, sensor_fault;

  int total = 0;
  int bad   = 0;

  localparam logic [39:0] GOOD  = 40'h3700190050;
  localparam logic [39:0] BADCS = 40'h3700190051;
  localparam logic [39:0] ALT   = 40'h2A0014003E;

  dht_frame_check #(.TIMEOUT_CYC(100), .MAX_FAIL(3)) dut (
    .clk1M(clk1M), .rst_n(rst_n), .frame_in(frame_in), .frame_stb(frame_stb),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .data_valid(data_valid), .upd_pulse(upd_pulse), .stale(stale),
    .sensor_fault(sensor_fault), .crc_err_cnt(crc_err_cnt)
  );

  always #5 clk1M = ~clk1M;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk1M);
  endtask

  task automatic do_reset();
    @(negedge clk1M);
    rst_n = 1'b0;
    frame_stb = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  // Ends at the negedge of the CHECK cycle (N+1).
  task automatic strobe(input logic [39:0] f);
    frame_in  = f;
    frame_stb = 1'b1;
    step(1);
    frame_stb = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (hum_int !== 8'h00 || hum_dec !== 8'h00 || temp_int !== 8'h00 || temp_dec !== 8'h00) begin
      bad++; $display("FAIL reset_bytes got %h %h %h %h want 0", hum_int, hum_dec, temp_int, temp_dec); end
    total++; if ({data_valid, upd_pulse, stale, sensor_fault} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got %b want 0000", {data_valid, upd_pulse, stale, sensor_fault}); end
    total++; if (crc_err_cnt !== 8'd0) begin
      bad++; $display("FAIL reset_crc got %0d want 0", crc_err_cnt); end
  endtask

  task automatic test_good_frame();
    do_reset();
    strobe(GOOD);
    step(1);
    total++; if (upd_pulse !== 1'b0 || data_valid !== 1'b0) begin
      bad++; $display("FAIL good_early got upd=%b dv=%b want 0 0", upd_pulse, data_valid); end
    step(1);
    total++; if (upd_pulse !== 1'b1) begin
      bad++; $display("FAIL good_upd got %b want 1", upd_pulse); end
    total++; if (hum_int !== 8'h37 || hum_dec !== 8'h00 || temp_int !== 8'h19 || temp_dec !== 8'h00) begin
      bad++; $display("FAIL good_bytes got %h %h %h %h want 37 00 19 00", hum_int, hum_dec, temp_int, temp_dec); end
    total++; if (data_valid !== 1'b1 || crc_err_cnt !== 8'd0) begin
      bad++; $display("FAIL good_dv_crc got dv=%b crc=%0d want 1 0", data_valid, crc_err_cnt); end
    step(1);
    total++; if (upd_pulse !== 1'b0) begin
      bad++; $display("FAIL good_upd_one got %b want 0", upd_pulse); end
  endtask

  task automatic test_bad_checksum();
    strobe(BADCS);
    step(2);
    total++; if (hum_int !== 8'h37 || temp_int !== 8'h19 || data_valid !== 1'b1 || upd_pulse !== 1'b0) begin
      bad++; $display("FAIL badcs_hold got %h %h dv=%b upd=%b want 37 19 1 0", hum_int, temp_int, data_valid, upd_pulse); end
    total++; if (crc_err_cnt !== 8'd1 || sensor_fault !== 1'b0) begin
      bad++; $display("FAIL badcs_cnt got crc=%0d flt=%b want 1 0", crc_err_cnt, sensor_fault); end
  endtask

  task automatic test_fault_recovery();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      strobe(BADCS);
      step(2);
      total++; if (sensor_fault !== (i == 3) || crc_err_cnt !== 8'(i)) begin
        bad++; $display("FAIL fault_%0d got flt=%b crc=%0d want %b %0d", i, sensor_fault, crc_err_cnt, (i == 3), i); end
    end
    strobe(GOOD);
    step(2);
    total++; if (sensor_fault !== 1'b0 || crc_err_cnt !== 8'd3 || data_valid !== 1'b1 || hum_int !== 8'h37) begin
      bad++; $display("FAIL recovery got flt=%b crc=%0d dv=%b hum=%h want 0 3 1 37", sensor_fault, crc_err_cnt, data_valid, hum_int); end
  endtask

  task automatic test_zero_range();
    do_reset();
    strobe(40'h0);
    step(2);
    total++; if (crc_err_cnt !== 8'd1 || data_valid !== 1'b0 || upd_pulse !== 1'b0) begin
      bad++; $display("FAIL zero_frame got crc=%0d dv=%b upd=%b want 1 0 0", crc_err_cnt, data_valid, upd_pulse); end
    strobe(40'h650019007E);
    step(2);
`ifdef DHT_PLAUSIBILITY_EN
    total++; if (crc_err_cnt !== 8'd2 || hum_int !== 8'h00 || data_valid !== 1'b0) begin
      bad++; $display("FAIL range_reject got crc=%0d hum=%h dv=%b want 2 00 0", crc_err_cnt, hum_int, data_valid); end
`else
    total++; if (crc_err_cnt !== 8'd1 || hum_int !== 8'h65 || data_valid !== 1'b1 || upd_pulse !== 1'b1) begin
      bad++; $display("FAIL range_commit got crc=%0d hum=%h dv=%b upd=%b want 1 65 1 1", crc_err_cnt, hum_int, data_valid, upd_pulse); end
`endif
  endtask

  task automatic test_stale();
    do_reset();
    strobe(GOOD);
    step(2);
    step(98);
    total++; if (stale !== 1'b0 || data_valid !== 1'b1) begin
      bad++; $display("FAIL stale_early got stale=%b dv=%b want 0 1", stale, data_valid); end
    step(5);
    total++; if (stale !== 1'b1 || data_valid !== 1'b0 || hum_int !== 8'h37 || temp_int !== 8'h19) begin
      bad++; $display("FAIL stale_set got stale=%b dv=%b hum=%h tmp=%h want 1 0 37 19", stale, data_valid, hum_int, temp_int); end
    strobe(GOOD);
    step(2);
    total++; if (stale !== 1'b0 || data_valid !== 1'b1) begin
      bad++; $display("FAIL stale_clear got stale=%b dv=%b want 0 1", stale, data_valid); end
  endtask

  task automatic test_crc_saturate();
    do_reset();
    for (int i = 0; i < 258; i++) begin
      strobe(BADCS);
      step(2);
    end
    total++; if (crc_err_cnt !== 8'd255 || sensor_fault !== 1'b1) begin
      bad++; $display("FAIL crc_sat got crc=%0d flt=%b want 255 1", crc_err_cnt, sensor_fault); end
  endtask

  task automatic test_reset_mid();
    int upd_seen;
    do_reset();
    strobe(GOOD);
    rst_n = 1'b0;
    #1;
    total++; if (hum_int !== 8'h00 || data_valid !== 1'b0 || upd_pulse !== 1'b0 || crc_err_cnt !== 8'd0) begin
      bad++; $display("FAIL rst_mid got hum=%h dv=%b upd=%b crc=%0d want 00 0 0 0", hum_int, data_valid, upd_pulse, crc_err_cnt); end
    step(1);
    rst_n = 1'b1;
    upd_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      if (upd_pulse === 1'b1) upd_seen++;
    end
    total++; if (upd_seen != 0 || hum_int !== 8'h00 || data_valid !== 1'b0) begin
      bad++; $display("FAIL rst_no_commit got upd=%0d hum=%h dv=%b want 0 00 0", upd_seen, hum_int, data_valid); end
  endtask

  task automatic test_back_to_back();
    int upd_seen;
    do_reset();
    strobe(GOOD);
    strobe(ALT);
    upd_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (upd_pulse === 1'b1) upd_seen++;
      step(1);
    end
    total++; if (upd_seen != 1 || hum_int !== 8'h37 || temp_int !== 8'h19 || crc_err_cnt !== 8'd0) begin
      bad++; $display("FAIL busy_stb got upd=%0d hum=%h tmp=%h crc=%0d want 1 37 19 0", upd_seen, hum_int, temp_int, crc_err_cnt); end
    strobe(ALT);
    step(2);
    total++; if (hum_int !== 8'h2A || temp_int !== 8'h14 || upd_pulse !== 1'b1) begin
      bad++; $display("FAIL next_frame got hum=%h tmp=%h upd=%b want 2a 14 1", hum_int, temp_int, upd_pulse); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_fault_recovery();
    test_zero_range();
    test_stale();
    test_crc_saturate();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
